// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for a word-addressed, registered-read data memory.
// Accepts one byte-addressed access at a time, runs the memory read/write cycles
// (read-modify-write for byte/half stores) and returns aligned, extended load data.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_unsigned  store flag, 00 byte / 01 half / 10 word, zero-extend
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid/resp_ready           response handshake (response held while stalled)
//   resp_rdata, resp_err            load result, error flag
//   mem_en, mem_r_w, mem_address    memory strobe, 1 = write, word index
//   mem_in, mem_out                 write data, read data (valid the cycle after a read)
module dmem_lsu #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_r_w,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 30;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RCAP = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [DW-1:0]   resp_rdata_q;
  logic            resp_err_q;
  logic            mem_en_q;
  logic            mem_r_w_q;
  logic [DW-1:0]   mem_address_q;
  logic [DW-1:0]   mem_in_q;

  // Latched request attributes
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [15:0]     wdata_q;

  logic            err_d;
  logic [DW-1:0]   load_d;
  logic [DW-1:0]   merge_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [4:0]      bit_off;

  // Request legality: illegal size, misalignment, or word index beyond the memory
  always_comb begin
    err_d = 1'b0;
    if (req_size == 2'b11)                            err_d = 1'b1;
    if (req_size == 2'b01 && req_addr[0])             err_d = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  err_d = 1'b1;
    if (req_addr[31:2] >= IW'(DEPTH))                 err_d = 1'b1;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    bit_off  = {off_q, 3'b000};
    byte_sel = 8'(mem_out >> bit_off);
    half_sel = off_q[1] ? mem_out[31:16] : mem_out[15:0];
    load_d   = mem_out;
    merge_d  = mem_out;
    case (size_q)
      2'b00: begin
        load_d = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        case (off_q)
          2'd0:    merge_d[7:0]   = wdata_q[7:0];
          2'd1:    merge_d[15:8]  = wdata_q[7:0];
          2'd2:    merge_d[23:16] = wdata_q[7:0];
          default: merge_d[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        load_d = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        if (off_q[1]) merge_d[31:16] = wdata_q;
        else          merge_d[15:0]  = wdata_q;
      end
      default: begin
        load_d  = mem_out;
        merge_d = mem_out;
      end
    endcase
  end

  // Control FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_r_w_q     <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      wdata_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q   <= 1'b0;
            we_q          <= req_we;
            size_q        <= req_size;
            uns_q         <= req_unsigned;
            off_q         <= req_addr[1:0];
            wdata_q       <= req_wdata[15:0];
            mem_address_q <= {2'b00, req_addr[31:2]};
            if (err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_we && req_size == 2'b10) begin
              state_q   <= S_WR;
              mem_en_q  <= 1'b1;
              mem_r_w_q <= 1'b1;
              mem_in_q  <= req_wdata;
            end else begin
              state_q   <= S_RD;
              mem_en_q  <= 1'b1;
              mem_r_w_q <= 1'b0;
            end
          end
        end
        S_RD: begin
          state_q  <= S_RCAP;
          mem_en_q <= 1'b0;
        end
        S_RCAP: begin
          if (we_q) begin
            state_q   <= S_WR;
            mem_en_q  <= 1'b1;
            mem_r_w_q <= 1'b1;
            mem_in_q  <= merge_d;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_d;
          end
        end
        S_WR: begin
          state_q      <= S_RESP;
          mem_en_q     <= 1'b0;
          mem_r_w_q    <= 1'b0;
          mem_in_q     <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q       <= S_IDLE;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            req_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_r_w_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_en      = mem_en_q;
  assign mem_r_w     = mem_r_w_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a driver issues requests and pushes the reference
// model's expected response; a monitor pops and compares whenever a response appears.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_r_w;
  logic [31:0] mem_address, mem_in, mem_out;

  dmem_lsu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_r_w(mem_r_w), .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
    int          writes;
    int          reads;
    logic [31:0] idx;
    logic        is_store;
    logic [31:0] wword;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] mem     [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  int          stall_left = 0;
  logic        in_resp = 1'b0;
  logic        hs_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: registered read, write on enabled write cycles
  always @(posedge clk) begin
    cyc++;
    if (mem_en) begin
      last_addr = mem_address;
      if (mem_address >= 32'(DEPTH)) begin
        chk("mem_addr_range", mem_address, 32'(DEPTH - 1));
      end else if (mem_r_w) begin
        wr_cnt++;
        last_wdata = mem_in;
        mem[mem_address] = mem_in;
      end else begin
        rd_cnt++;
        mem_out <= mem[mem_address];
      end
    end
  end

  // Reference model: behaviour derived from byte lanes of a little-endian word array
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd, output int lat);
    int nbytes = 1 << size;
    int off = int'(addr % 4);
    logic [31:0] idx = addr / 4;
    logic [31:0] word;
    logic [31:0] val = '0;
    err = (size == 2'd3) || ((addr % nbytes) != 0) || (idx >= 32'(DEPTH));
    rd  = '0;
    if (err) begin
      lat = 1;
      return;
    end
    word = ref_mem[idx];
    if (we) begin
      for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = word;
      lat = (nbytes == 4) ? 2 : 4;
    end else begin
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
      if (!uns && nbytes < 4 && val[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) val[8*i +: 8] = 8'hFF;
      rd  = val;
      lat = 3;
    end
  endfunction

  // Driver: present a request, wait for acceptance, push the expectation
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    e.acc_cyc  = cyc;
    e.writes   = wr_cnt;
    e.reads    = rd_cnt;
    e.idx      = addr / 4;
    e.is_store = we;
    model(we, size, uns, addr, wdata, e.err, e.rdata, e.lat);
    if (!e.err && we) e.writes++;
    if (!e.err && !(we && size == 2'd2)) e.reads++;
    e.wword = e.err ? 32'd0 : ref_mem[e.idx];
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (q.size() != 0 || in_resp) begin
      @(negedge clk);
      w++;
      if (w > 200) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: pops on a new response, checks it every cycle it is held, drives resp_ready
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp    = 1'b0;
      hs_prev    = 1'b0;
      resp_ready = 1'b0;
    end else begin
      if (hs_prev) chk("req_ready_after_hs", 32'(req_ready), 32'd1);
      if (resp_valid) begin
        if (!in_resp) begin
          if (q.size() == 0) begin
            chk("spurious_resp", 32'(resp_valid), 32'd0);
          end else begin
            cur = q.pop_front();
            in_resp = 1'b1;
            chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
            chk("mem_writes", 32'(wr_cnt), 32'(cur.writes));
            chk("mem_reads", 32'(rd_cnt), 32'(cur.reads));
            if (!cur.err) chk("mem_address", last_addr, cur.idx);
            if (!cur.err && cur.is_store) chk("mem_in", last_wdata, cur.wword);
          end
        end
        if (in_resp) begin
          chk("resp_rdata", resp_rdata, cur.rdata);
          chk("resp_err", 32'(resp_err), 32'(cur.err));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
        end
      end
      if (stall_left > 0 && resp_valid) begin
        resp_ready = 1'b0;
        stall_left--;
      end else begin
        resp_ready = ($urandom_range(0, 3) != 0);
      end
      hs_prev = resp_valid && resp_ready;
      if (hs_prev) in_resp = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_w;
    logic [31:0] a;
    for (int i = 0; i < int'(DEPTH); i++) begin
      a = $urandom;
      ref_mem[i] = a;
      mem[i] = a;
    end
    mem_out = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_r_w", 32'(mem_r_w), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_in", mem_in, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Directed accesses
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd0, 1'b0, 32'h14 + 32'(i), 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h15, 32'h000000AB);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h16, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h14, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);

    // Response held for five cycles, then released
    wait_idle();
    stall_left = 5;
    issue(1'b0, 2'd0, 1'b0, 32'h17, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h14, 32'h0);

    // Reset during the read phase of a byte store
    wait_idle();
    base_w = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h15;
    req_wdata = 32'h5A; req_valid = 1'b1;
    chk("rr_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rr_in_rd", 32'({mem_en, mem_r_w}), 32'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr_req_ready_low", 32'(req_ready), 32'd0);
    chk("rr_mem_en_low", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_req_ready_high", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rr_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("rr_no_write", 32'(wr_cnt), 32'(base_w));

    // Randomized traffic over a small window plus out-of-range and illegal cases
    for (int n = 0; n < 300; n++) begin
      logic [31:0] idx;
      logic [1:0]  sz;
      idx = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(2045, 2050)) : 32'($urandom_range(0, 7));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            idx * 4 + 32'($urandom_range(0, 3)), $urandom);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
